// File: rtl/ex_alu_if.sv
// ex_alu_if: operand/result bundle between the ID/EX stage and ex_alu_unit.
//   master: drives Flush, InValid, ALUControl, A, B, Shamt; observes results.
//   slave : the execution unit; drives Busy, OutValid, ALUResult, Zero
//           (plus Hi, HiValid when EX_ALU_MULT_HI_EN is defined).
interface ex_alu_if #(parameter int WIDTH = 32);
  logic             Flush;
  logic             InValid;
  logic [4:0]       ALUControl;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic [4:0]       Shamt;
  logic             Busy;
  logic             OutValid;
  logic [WIDTH-1:0] ALUResult;
  logic             Zero;
`ifdef EX_ALU_MULT_HI_EN
  logic [WIDTH-1:0] Hi;
  logic             HiValid;
`endif
  modport master(output Flush, InValid, ALUControl, A, B, Shamt,
                 input Busy, OutValid, ALUResult, Zero
`ifdef EX_ALU_MULT_HI_EN
                 , input Hi, HiValid
`endif
                 );
  modport slave(input Flush, InValid, ALUControl, A, B, Shamt,
                output Busy, OutValid, ALUResult, Zero
`ifdef EX_ALU_MULT_HI_EN
                , output Hi, HiValid
`endif
                );
endinterface

// File: rtl/ex_alu_unit.sv
// ex_alu_unit: EX-stage ALU with 1-cycle ops and an iterative shift-add signed multiplier.
//   Clk : pipeline clock (rising edge)
//   Rst : synchronous active-low reset
//   bus : ex_alu_if.slave (Flush, InValid, ALUControl, A, B, Shamt -> Busy, OutValid, ALUResult, Zero)
//   Optional macro EX_ALU_MULT_HI_EN adds Hi/HiValid with a 2*WIDTH product.
module ex_alu_unit #(
  parameter int WIDTH = 32
) (
  input logic     Clk,
  input logic     Rst,
  ex_alu_if.slave bus
);
`ifdef EX_ALU_MULT_HI_EN
  localparam int AW = 2 * WIDTH;
`else
  localparam int AW = WIDTH;
`endif
  localparam int CW = $clog2(WIDTH) + 1;
  typedef enum logic [1:0] {IDLE, MUL, DONE} state_t;
  state_t           r_state;
  logic [CW-1:0]    r_cnt;
  logic [WIDTH-1:0] r_mcand;
  logic [AW-1:0]    r_mplier;
  logic [AW-1:0]    r_acc;
  logic             r_sign;
  logic [WIDTH-1:0] r_result;
  logic             r_zero;
  logic             r_outvalid;
  logic [WIDTH-1:0] w_res;
  logic [WIDTH-1:0] w_abs_a;
  logic [WIDTH-1:0] w_abs_b;
  logic [AW-1:0]    w_prod;
  logic             w_is_mul;
  assign w_is_mul = bus.ALUControl == 5'b00011;
  assign w_abs_a  = bus.A[WIDTH-1] ? -bus.A : bus.A;
  assign w_abs_b  = bus.B[WIDTH-1] ? -bus.B : bus.B;
  // magnitudes are multiplied; the sign is reapplied to the whole product
  assign w_prod   = r_sign ? -r_acc : r_acc;
  always_comb begin
    w_res = '0;
    case (bus.ALUControl)
      5'b00000, 5'b00001: w_res = bus.A + bus.B;
      5'b00010: w_res = bus.A - bus.B;
      5'b10011: w_res = bus.A & bus.B;
      5'b10101: w_res = bus.A | bus.B;
      5'b10110: w_res = ~(bus.A | bus.B);
      5'b10111: w_res = bus.A ^ bus.B;
      5'b11010: w_res = bus.B << bus.Shamt;
      5'b11011: w_res = bus.B >> bus.Shamt;
      5'b11100: w_res = {{(WIDTH-1){1'b0}}, $signed(bus.A) < $signed(bus.B)};
      default:  w_res = '0;
    endcase
  end
`ifdef EX_ALU_MULT_HI_EN
  logic [WIDTH-1:0] r_hi;
  logic             r_hivalid;
  always_ff @(posedge Clk) begin
    if (!Rst) begin
      r_hi      <= '0;
      r_hivalid <= 1'b0;
    end else if (bus.Flush) begin
      r_hivalid <= 1'b0;
    end else if (r_state == MUL && r_cnt == CW'(WIDTH)) begin
      r_hi      <= w_prod[AW-1:WIDTH];
      r_hivalid <= 1'b1;
    end else begin
      r_hivalid <= 1'b0;
    end
  end
  assign bus.Hi      = r_hi;
  assign bus.HiValid = r_hivalid;
`endif
  always_ff @(posedge Clk) begin
    if (!Rst) begin
      r_state    <= IDLE;
      r_cnt      <= '0;
      r_mcand    <= '0;
      r_mplier   <= '0;
      r_acc      <= '0;
      r_sign     <= 1'b0;
      r_result   <= '0;
      r_zero     <= 1'b1;
      r_outvalid <= 1'b0;
    end else if (bus.Flush) begin
      r_state    <= IDLE;
      r_acc      <= '0;
      r_outvalid <= 1'b0;
    end else if (r_state == MUL) begin
      // WIDTH iterations, then the final MUL edge publishes the product
      if (r_cnt != CW'(WIDTH)) begin
        if (r_mcand[0]) r_acc <= r_acc + r_mplier;
        r_mplier   <= r_mplier << 1;
        r_mcand    <= r_mcand >> 1;
        r_cnt      <= r_cnt + 1'b1;
        r_outvalid <= 1'b0;
      end else begin
        r_result   <= w_prod[WIDTH-1:0];
        r_zero     <= w_prod[WIDTH-1:0] == '0;
        r_outvalid <= 1'b1;
        r_state    <= DONE;
      end
    end else begin
      r_outvalid <= bus.InValid && !w_is_mul;
      r_state    <= (bus.InValid && w_is_mul) ? MUL : IDLE;
      if (bus.InValid && w_is_mul) begin
        r_mcand  <= w_abs_a;
        r_mplier <= AW'(w_abs_b);
        r_acc    <= '0;
        r_sign   <= bus.A[WIDTH-1] ^ bus.B[WIDTH-1];
        r_cnt    <= '0;
      end else if (bus.InValid) begin
        r_result <= w_res;
        r_zero   <= w_res == '0;
      end
    end
  end
  assign bus.Busy      = r_state == MUL;
  assign bus.OutValid  = r_outvalid;
  assign bus.ALUResult = r_result;
  assign bus.Zero      = r_zero;
endmodule
